// File: rtl/spi_peripheral_responder.sv
// SPI link responder: decodes controller frames into a 16-entry register file and serializes reads.
// Optional build macro SPI_RESP_STATUS_EN turns address 15 into a read-only status register.
module spi_peripheral_responder #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                   axi_clk,
    input  logic                   reset_b,
    input  logic                   cs_b_i,
    input  logic                   pico_i,
    output logic                   poci_o,
    output logic [16*DATA_W-1:0]   regs_flat_o,
    output logic                   wr_strobe_o,
    output logic [3:0]             wr_addr_o,
    output logic                   frame_active_o
);

    typedef enum logic [1:0] {StIdle, StAddr, StWdata, StRdata} state_e;

    state_e              state_q;
    logic                armed_q;
    logic                wnr_q;
    logic [2:0]          bit_cnt_q;
    logic [3:0]          addr_q;
    logic [7:0]          data_cnt_q;
    logic [DATA_W-1:0]   rx_shift_q;
    logic [DATA_W-1:0]   tx_shift_q;
    logic [DATA_W-1:0]   regs_q    [16];
    logic [DATA_W-1:0]   regs_view [16];
    logic [3:0]          rd_addr;
    logic                wr_allowed;

`ifdef SPI_RESP_STATUS_EN
    logic [7:0]          commit_cnt_q;
    logic [7:0]          abort_cnt_q;
    logic [DATA_W-1:0]   status;

    always_comb begin
        status       = '0;
        status[15:0] = {abort_cnt_q, commit_cnt_q};
    end

    assign wr_allowed = (addr_q != 4'hF);
`else
    assign wr_allowed = 1'b1;
`endif

    // Address completes on the k=4 edge, so the read index uses the incoming bit directly.
    assign rd_addr = {addr_q[2:0], pico_i};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_view[i] = regs_q[i];
        end
`ifdef SPI_RESP_STATUS_EN
        regs_view[15] = status;
`endif
        regs_flat_o = '0;
        for (int i = 0; i < 16; i++) begin
            regs_flat_o[i*DATA_W +: DATA_W] = regs_view[i];
        end
    end

    assign poci_o         = tx_shift_q[DATA_W-1] & (state_q == StRdata);
    assign frame_active_o = (state_q != StIdle);

    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            wnr_q        <= 1'b0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            data_cnt_q   <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            wr_strobe_o  <= 1'b0;
            wr_addr_o    <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
`ifdef SPI_RESP_STATUS_EN
            commit_cnt_q <= '0;
            abort_cnt_q  <= '0;
`endif
        end else begin
            wr_strobe_o <= 1'b0;
            // A frame may only start after cs_b has been seen high since reset.
            if (cs_b_i) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (!cs_b_i && armed_q) begin
                        state_q   <= StAddr;
                        wnr_q     <= pico_i;
                        bit_cnt_q <= 3'd1;
                    end
                end
                StAddr: begin
                    if (cs_b_i) begin
                        state_q   <= StIdle;
                        bit_cnt_q <= '0;
`ifdef SPI_RESP_STATUS_EN
                        if (abort_cnt_q != 8'hFF) begin
                            abort_cnt_q <= abort_cnt_q + 8'd1;
                        end
`endif
                    end else begin
                        addr_q    <= rd_addr;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd4) begin
                            bit_cnt_q <= '0;
                            if (wnr_q) begin
                                state_q    <= StWdata;
                                rx_shift_q <= '0;
                                data_cnt_q <= '0;
                            end else begin
                                state_q    <= StRdata;
                                tx_shift_q <= regs_view[rd_addr];
                            end
                        end
                    end
                end
                StWdata: begin
                    if (cs_b_i) begin
                        state_q    <= StIdle;
                        rx_shift_q <= '0;
                        data_cnt_q <= '0;
                        if (data_cnt_q != 8'd0 && wr_allowed) begin
                            regs_q[addr_q] <= rx_shift_q;
                            wr_strobe_o    <= 1'b1;
                            wr_addr_o      <= addr_q;
`ifdef SPI_RESP_STATUS_EN
                            commit_cnt_q   <= commit_cnt_q + 8'd1;
`endif
                        end
                    end else begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], pico_i};
                        if (data_cnt_q != 8'hFF) begin
                            data_cnt_q <= data_cnt_q + 8'd1;
                        end
                    end
                end
                StRdata: begin
                    if (cs_b_i) begin
                        state_q    <= StIdle;
                        tx_shift_q <= '0;
                    end else begin
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/spi_peripheral_responder.md
# spi_peripheral_responder

Responder end of the SPARKDream generic SPI link: decodes frames issued by the FPGA SPI controller (`cs_b`/`pico`) and answers reads on `poci`. It is clocked on the same `axi_clk` that the controller forwards as `spi_clk`. It holds a 16-entry register file and exposes it in parallel to on-chip logic. It is used as the SP3-side peripheral model and as an FPGA loopback target for controller bring-up.

## Interface
- `DATA_W`, 32, register width in bits; legal range 16..32.
- `axi_clk` in 1: clock; all link signals are sampled on its rising edge.
- `reset_b` in 1: reset, asynchronous, active-low; clock `axi_clk`.
- `cs_b` in 1: frame select, active-low.
- `pico` in 1: serial data from the controller.
- `poci` out 1: serial read data to the controller.
- `regs_flat` out 16*DATA_W: register file, entry n in bits `[n*DATA_W +: DATA_W]`.
- `wr_strobe` out 1: one-cycle pulse when a write commits.
- `wr_addr` out 4: address of the last commit; holds its value between commits.
- `frame_active` out 1: high while a frame is being decoded (state != IDLE).

## Operation
- Frame bit k is sampled at the k-th edge with `cs_b`=0, counting from k=0.
  - k=0: WnR, where 1 = write.
  - k=1..4: address, MSB first.
  - k>=5: data, MSB first, of arbitrary length 0..255.
- A frame ends at the first edge where `cs_b`=1.
- States:
  - IDLE → ADDR on `cs_b`=0; latch WnR and set `bit_cnt`=1.
  - ADDR: shift `pico` into `addr`. At k=4, go to WDATA if WnR=1, else RDATA. Entering RDATA loads `tx_shift` <= entry[{addr[2:0],pico}].
  - WDATA: `rx_shift` <= {`rx_shift`[DATA_W-2:0], `pico`}, counting data bits in 8 bits, saturating at 255.
  - RDATA: `tx_shift` <= {`tx_shift`[DATA_W-2:0], 1'b0}.
  - Any state with `cs_b`=1 → IDLE.
- Commit happens at the ending edge of a frame that was in WDATA with at least 1 data bit:
  - entry[addr] <= `rx_shift`;
  - `wr_strobe` <= 1;
  - `wr_addr` <= addr.
- Write-length rules:
  - Fewer than DATA_W data bits: the value is right-justified and zero-extended, because `rx_shift` is cleared on entry to WDATA.
  - More than DATA_W data bits: the last DATA_W bits are kept.
- Abort: a frame that ends in ADDR (fewer than 5 bits) is discarded and performs no write. A write frame with 0 data bits is also a no-op.
- Reads beyond DATA_W bits return 0.
- A read frame leaves the register file unchanged.
- `rx_shift` and `tx_shift` are cleared on return to IDLE.

## Timing
- Reset values are all 0: `poci`, `regs_flat`, `wr_strobe`, `wr_addr`, `frame_active`, state = IDLE, and all counters and shift registers.
- `poci` = `tx_shift`[DATA_W-1] & (state==RDATA), driven from flops only with no combinational path from `pico`/`cs_b`.
  - The controller's read-data bit j (frame bit 5+j) sees entry bit DATA_W-1-j in the cycle after the k=4 edge, with zero turnaround bubble.
- Write latency: `regs_flat` and `wr_strobe` update at the `cs_b`-high edge and are visible in the following cycle. `wr_strobe` is high for exactly one cycle.
- Back-to-back frames: one `cs_b`-high cycle between frames is sufficient. `cs_b`=0 in the cycle after the commit edge starts a new frame normally.
- `frame_active` rises one cycle after the first `cs_b`=0 edge and falls one cycle after the ending edge.
- Reset mid-frame: everything returns to reset values immediately, with no commit. After `reset_b` releases, a frame starts only on a fresh `cs_b` falling edge: the block waits for `cs_b`=1 before leaving IDLE.

## Configuration
- `SPI_RESP_STATUS_EN` defined: address 15 is a read-only status register.
  - Bits [7:0]: committed-write count, wrapping.
  - Bits [15:8]: aborted-frame count, saturating at 255.
  - Upper bits: 0.
  - Writes to address 15 are ignored: no `wr_strobe`, no change.
  - `regs_flat` entry 15 shows the status value.
- `SPI_RESP_STATUS_EN` undefined: address 15 is an ordinary read/write register, and the counters are not built.

## Test plan
- Write 0xA5A51234 to addr 3: `cs_b` low for 37 cycles with bits 1,0,0,1,1 and then the data MSB first, followed by 1 cycle of `cs_b` high → `wr_strobe`=1 for 1 cycle, `wr_addr`=3, entry 3 = 0xA5A51234.
- Read addr 3 with 32 data bits after the test above → `poci` serializes 0xA5A51234 MSB first starting at frame bit 5, with no write strobe.
- Short and long writes:
  - 8-bit write of 0xC3 to addr 5 → entry 5 = 0x000000C3.
  - 40-bit write of 0xFF_DEADBEEF to addr 6 → entry 6 = 0xDEADBEEF.
  - A 40-bit read of addr 6 → bits 32..39 read back as 0.
- Abort: `cs_b` low for 3 bits, then high → no `wr_strobe`, register file unchanged. With the macro defined, a read of addr 15 then returns 0x00000100.
- Back-to-back write to addr 1 then read of addr 1, separated by 1 idle cycle → the read returns the newly written value.
- Assert `reset_b` at frame bit 20 of a write to addr 2 → no commit, all outputs 0. Keeping `cs_b` low after release starts no frame; the next full frame works.
